// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for a multi-cycle divider: latches operands, holds start while
// the divider runs, stalls the pipe until the result is back and presents HI/LO for write-back.
module div_issue_ctrl #(
  parameter int W          = 32,
  parameter int FLUSH_WAIT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           div_req_i,
  input  logic           signed_i,
  input  logic [W-1:0]   src_a_i,
  input  logic [W-1:0]   src_b_i,
  input  logic           stall_i,
  input  logic           flush_i,
  input  logic [2*W-1:0] div_result_i,
  input  logic           div_ready_i,
  output logic           div_start_o,
  output logic           div_annul_o,
  output logic           div_signed_o,
  output logic [W-1:0]   div_op1_o,
  output logic [W-1:0]   div_op2_o,
  output logic           stall_req_o,
  output logic [W-1:0]   hi_o,
  output logic [W-1:0]   lo_o,
  output logic           hilo_we_o
);

  localparam int CW = $clog2(FLUSH_WAIT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [1:0] S_CANCEL = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          signed_q, signed_d;
  logic [W-1:0]  op1_q, op1_d;
  logic [W-1:0]  op2_q, op2_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (div_req_i && !flush_i) begin
          signed_d = signed_i;
          op1_d    = src_a_i;
          op2_d    = src_b_i;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        // A flush wins over a result arriving in the same cycle.
        if (flush_i) begin
          cnt_d   = '0;
          state_d = S_CANCEL;
        end else if (div_ready_i) begin
          hi_d    = div_result_i[2*W-1:W];
          lo_d    = div_result_i[W-1:0];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (flush_i || !stall_i) begin
          state_d = S_IDLE;
        end
      end
      S_CANCEL: begin
        // Give the annulled divider time to drain back to its free state.
        if (cnt_q == CW'(FLUSH_WAIT - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      signed_q <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign div_start_o  = (state_q == S_BUSY);
  assign div_annul_o  = (state_q == S_BUSY) && flush_i;
  assign stall_req_o  = (state_q == S_BUSY) || ((state_q == S_IDLE) && div_req_i && !flush_i);
  assign hilo_we_o    = (state_q == S_DONE) && !flush_i;
  assign div_signed_o = signed_q;
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;

endmodule
